// File: rtl/inst_loader.sv
// Program loader: turns a length-prefixed byte stream into little-endian 32-bit
// instruction-memory writes and holds the core in reset until a load checks out.
module inst_loader #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        dbg_state_o
);

    // Handshake: a byte moves on a rising edge only when in_valid_i and
    // in_ready_o are both high; in_ready_o is high only in LEN_LO/LEN_HI/DATA/CSUM.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_t            state_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [31:0]       mem_wdata_q;
    logic              cpu_hold_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   widx_q;
    logic [1:0]        bidx_q;
    logic [23:0]       word_q;
    logic [7:0]        xor_q;

    logic              take;
    logic [15:0]       len_d;
    logic [ADDR_W:0]   widx_d;

    assign take   = in_valid_i & in_ready_q;
    assign len_d  = {in_data_i, len_q[7:0]};
    assign widx_d = widx_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            len_q       <= '0;
            widx_q      <= '0;
            bidx_q      <= '0;
            word_q      <= '0;
            xor_q       <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state_q    <= S_LEN_LO;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        len_q      <= '0;
                        widx_q     <= '0;
                        bidx_q     <= '0;
                        xor_q      <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (take) begin
                        len_q[7:0] <= in_data_i;
                        state_q    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (take) begin
                        len_q <= len_d;
                        if (len_d == 16'd0 || len_d > DEPTH16) begin
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        xor_q  <= xor_q ^ in_data_i;
                        bidx_q <= bidx_q + 1'b1;
                        case (bidx_q)
                            2'd0: word_q[7:0]   <= in_data_i;
                            2'd1: word_q[15:8]  <= in_data_i;
                            2'd2: word_q[23:16] <= in_data_i;
                            default: begin
                                // Fourth byte: publish the word; in_ready stays high.
                                mem_we_q    <= 1'b1;
                                mem_waddr_q <= widx_q[ADDR_W-1:0];
                                mem_wdata_q <= {in_data_i, word_q};
                                widx_q      <= widx_d;
                                if ({{(15-ADDR_W){1'b0}}, widx_d} == len_q)
                                    state_q <= S_CSUM;
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (take) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (in_data_i == xor_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_waddr_o = mem_waddr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign cpu_hold_o  = cpu_hold_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: frame driver, write scoreboard with an expected queue,
// status checks after each load, and a one-line final report.
module tb_inst_loader;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int W      = ADDR_W + 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  inst_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .mem_we_o   (mem_we),
    .mem_waddr_o(mem_waddr),
    .mem_wdata_o(mem_wdata),
    .cpu_hold_o (cpu_hold),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   frame_q[$];
  logic [31:0]  pay_q[$];

  bit bb_check  = 1'b0;
  bit have_prev = 1'b0;
  int prev_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_waddr, mem_wdata);
      end else begin
        check("mem_write", 64'({mem_waddr, mem_wdata}), 64'(exp_q.pop_front()));
      end
      if (bb_check && have_prev) check("word_spacing", 64'(cyc - prev_cyc), 64'd4);
      have_prev = 1'b1;
      prev_cyc  = cyc;
    end
  end

  // driver tasks (all begin and end at posedge+1)
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Build frame from pay_q; csum is the XOR of payload bytes (or 0x00 if bad_csum).
  task automatic build_frame(input logic [15:0] n, input bit with_payload, input bit bad_csum);
    logic [7:0] x;
    x = 8'h00;
    frame_q.delete();
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    if (with_payload) begin
      for (int i = 0; i < pay_q.size(); i++) begin
        for (int k = 0; k < 4; k++) begin
          frame_q.push_back(pay_q[i][8*k +: 8]);
          x = x ^ pay_q[i][8*k +: 8];
        end
        exp_q.push_back({7'(i), pay_q[i]});
      end
      frame_q.push_back(bad_csum ? 8'h00 : x);
    end
  endtask

  task automatic send_frame(input bit gaps, input bit starts);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          start = starts ? 1'($urandom_range(0, 1)) : 1'b0;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      send_byte(frame_q[i]);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got busy 1 expected 0");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string name, input bit e_done, input bit e_err, input bit e_hold);
    check({name, "_status"}, 64'({done, err, cpu_hold, busy, in_ready}),
          64'({e_done, e_err, e_hold, 1'b0, 1'b0}));
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run_load(input string name, input logic [15:0] n, input bit with_payload,
                          input bit bad_csum, input bit gaps, input bit starts,
                          input bit e_done, input bit e_err, input bit e_hold);
    have_prev = 1'b0;
    bb_check  = with_payload && !gaps;
    build_frame(n, with_payload, bad_csum);
    pulse_start();
    check({name, "_after_start"}, 64'({busy, cpu_hold, done, err, in_ready}), 64'b11001);
    send_frame(gaps, starts);
    wait_idle();
    bb_check = 1'b0;
    check_status(name, e_done, e_err, e_hold);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({in_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, done, err}),
          64'({1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // happy path
    pay_q = '{32'h0000_0013, 32'h0010_0093};
    run_load("happy", 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // bad checksum: writes still land
    run_load("bad_csum", 16'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // length bounds
    run_load("len_zero", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_load("len_129", 16'd129, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_load("len_big", 16'h0102, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    pay_q.delete();
    for (int i = 0; i < DEPTH; i++) pay_q.push_back($urandom());
    run_load("len_128", 16'd128, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // gaps plus start pulses while busy: same writes expected
    pay_q = '{32'h0000_0013, 32'h0010_0093, 32'hDEAD_BEEF};
    run_load("gaps", 16'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // reload after done
    pay_q = '{32'h0000_0073};
    run_load("reload", 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset mid-stream (last write left addr 0 / 0x73, done=1)
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 64'({in_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, done, err}),
          64'({1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_hold", 64'({cpu_hold, in_ready, busy}), 64'b100);
    exp_q.delete();

    pay_q = '{32'h0000_0073};
    run_load("after_reset", 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
